// File: rtl/conv_pkg.sv
// Shared definitions for the convolver control and datapath: default geometry,
// derived widths and the sequencer state encoding.
package conv_pkg;

  localparam int unsigned DATA_WIDTH  = 16;
  localparam int unsigned IMAGE_SIZE  = 28;
  localparam int unsigned KERNEL_SIZE = 5;

  localparam int unsigned OUT_SIZE = IMAGE_SIZE - KERNEL_SIZE + 1;
  localparam int unsigned NUM_W    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned AW       = $clog2(NUM_W);
  localparam int unsigned PW       = $clog2(IMAGE_SIZE);
  localparam int unsigned OW       = $clog2(OUT_SIZE);

  typedef enum logic [1:0] {
    StIdle,
    StLoadW,
    StStream,
    StDone
  } conv_state_e;

endpackage

// File: rtl/conv_pos_counter.sv
// Raster-order row/column counter for the incoming image, with flags for the
// final pixel and for positions that complete a full KxK window.
module conv_pos_counter #(
  parameter int unsigned IMAGE_SIZE  = 28,
  parameter int unsigned KERNEL_SIZE = 5,
  parameter int unsigned PW          = $clog2(IMAGE_SIZE)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clear,
  input  logic          inc,
  output logic [PW-1:0] row,
  output logic [PW-1:0] col,
  output logic          last,
  output logic          win_ok
);

  localparam logic [PW-1:0] PosMax   = PW'(IMAGE_SIZE - 1);
  localparam logic [PW-1:0] WinStart = PW'(KERNEL_SIZE - 1);

  logic [PW-1:0] row_q, row_d;
  logic [PW-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (inc) begin
      if (col_q == PosMax) begin
        col_d = '0;
        row_d = (row_q == PosMax) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row    = row_q;
  assign col    = col_q;
  assign last   = (row_q == PosMax) && (col_q == PosMax);
  assign win_ok = (row_q >= WinStart) && (col_q >= WinStart);

endmodule

// File: rtl/conv_window_sequencer.sv
// Frame sequencer for the convolver: loads the kernel into the weight store, then
// streams the image into the window buffer and flags valid KxK windows.
module conv_window_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned IMAGE_SIZE  = 28,
  parameter int unsigned KERNEL_SIZE = 5,
  localparam int unsigned NumW  = KERNEL_SIZE * KERNEL_SIZE,
  localparam int unsigned AddrW = $clog2(NumW),
  localparam int unsigned PosW  = $clog2(IMAGE_SIZE),
  localparam int unsigned OutW  = $clog2(IMAGE_SIZE - KERNEL_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  reuse_weights,
  output logic                  busy,
  output logic                  done,
  input  logic                  wt_valid,
  input  logic [DATA_WIDTH-1:0] wt_data,
  output logic                  wt_ready,
  output logic                  weight_write,
  output logic [AddrW-1:0]      weight_addr,
  output logic [DATA_WIDTH-1:0] weight_data,
  input  logic                  px_valid,
  input  logic [DATA_WIDTH-1:0] px_data,
  output logic                  px_ready,
  output logic                  shift_en,
  output logic [DATA_WIDTH-1:0] shift_data,
  output logic                  conv_valid,
  output logic [OutW-1:0]       out_row,
  output logic [OutW-1:0]       out_col,
  input  logic                  out_ready
);

  localparam logic [PosW-1:0]  WinStart = PosW'(KERNEL_SIZE - 1);
  localparam logic [AddrW-1:0] LastIdx  = AddrW'(NumW - 1);

  conv_state_e state_q, state_d;

  logic [AddrW-1:0]      wt_idx_q;
  logic                  px_done_q;
  logic                  weight_write_q, shift_en_q, conv_valid_q;
  logic [AddrW-1:0]      weight_addr_q;
  logic [DATA_WIDTH-1:0] weight_data_q, shift_data_q;
  logic [OutW-1:0]       out_row_q, out_col_q;

  logic            wt_hs, px_hs, consume;
  logic [PosW-1:0] row, col;
  logic            pos_last, win_ok;

  conv_pos_counter #(
    .IMAGE_SIZE (IMAGE_SIZE),
    .KERNEL_SIZE(KERNEL_SIZE),
    .PW         (PosW)
  ) u_pos (
    .clk   (clk),
    .rstn  (rstn),
    .clear (state_q == StIdle),
    .inc   (px_hs),
    .row   (row),
    .col   (col),
    .last  (pos_last),
    .win_ok(win_ok)
  );

  assign consume  = conv_valid_q & out_ready;
  assign wt_ready = (state_q == StLoadW);
  // Once the final pixel is in, refuse further pixels until the next frame.
  assign px_ready = (state_q == StStream) & ~(conv_valid_q & ~out_ready) & ~px_done_q;
  assign wt_hs    = wt_valid & wt_ready;
  assign px_hs    = px_valid & px_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = reuse_weights ? StStream : StLoadW;
      StLoadW:  if (wt_hs && (wt_idx_q == LastIdx)) state_d = StStream;
      StStream: if (consume && px_done_q) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= StIdle;
      wt_idx_q       <= '0;
      px_done_q      <= 1'b0;
      weight_write_q <= 1'b0;
      weight_addr_q  <= '0;
      weight_data_q  <= '0;
      shift_en_q     <= 1'b0;
      shift_data_q   <= '0;
      conv_valid_q   <= 1'b0;
      out_row_q      <= '0;
      out_col_q      <= '0;
    end else begin
      state_q        <= state_d;
      weight_write_q <= wt_hs;
      shift_en_q     <= px_hs;
      if (wt_hs) begin
        wt_idx_q      <= (wt_idx_q == LastIdx) ? '0 : wt_idx_q + 1'b1;
        weight_addr_q <= wt_idx_q;
        weight_data_q <= wt_data;
      end
      if (state_q == StIdle) begin
        px_done_q <= 1'b0;
      end else if (px_hs) begin
        px_done_q <= pos_last;
      end
      // A new pixel overrides a window being consumed in the same cycle.
      if (px_hs) begin
        shift_data_q <= px_data;
        conv_valid_q <= win_ok;
        if (win_ok) begin
          out_row_q <= OutW'(row - WinStart);
          out_col_q <= OutW'(col - WinStart);
        end
      end else if (consume) begin
        conv_valid_q <= 1'b0;
      end
    end
  end

  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StDone);
  assign weight_write = weight_write_q;
  assign weight_addr  = weight_addr_q;
  assign weight_data  = weight_data_q;
  assign shift_en     = shift_en_q;
  assign shift_data   = shift_data_q;
  assign conv_valid   = conv_valid_q;
  assign out_row      = out_row_q;
  assign out_col      = out_col_q;

endmodule
